// File: rtl/dds_wave_gen.sv
// Purpose: Avalon-MM programmed 32-bit phase accumulator producing saw/triangle/square/constant 10-bit samples; FTW changes staged to the next phase wrap.
// Latency: register write visible next cycle; acc -> dds_out 2 cycles; readdata registered, 1 cycle after address.
// Backpressure: none, one write per cycle with no wait states. Optional readback mux under DDS_WAVE_GEN_READBACK_EN (undefined: readdata tied to 0).
module dds_wave_gen #(
    parameter int PHASE_W = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                chipselect,
    input  logic                write,
    input  logic [1:0]          address,
    input  logic [31:0]         writedata,
    output logic [31:0]         readdata,
    output logic [9:0]          dds_out,
    output logic                phase_wrap
);

    typedef enum logic {ST_RUN, ST_PEND} state_t;

    state_t               r_state, w_state_nxt;
    logic [PHASE_W-1:0]   r_ftw_active, r_ftw_pend;
    logic [PHASE_W-1:0]   w_ftw_active_nxt, w_ftw_pend_nxt;
    logic [PHASE_W-1:0]   r_acc, r_poff;
    logic                 r_en;
    logic [1:0]           r_wave;
    logic [9:0]           r_level;
    logic [9:0]           r_ph;
    logic [9:0]           r_dds_out;
    logic                 r_phase_wrap;

    logic                 w_wr;
    logic                 w_wr_ftw, w_wr_poff, w_wr_ctrl, w_wr_level;
    logic                 w_clr;
    logic                 w_carry;
    logic [PHASE_W:0]     w_sum;
    logic [PHASE_W-1:0]   w_phase;
    logic [9:0]           w_tri_up;
    logic [9:0]           w_sample;

    assign w_wr       = chipselect & write;
    assign w_wr_ftw   = w_wr & (address == 2'd0);
    assign w_wr_poff  = w_wr & (address == 2'd1);
    assign w_wr_ctrl  = w_wr & (address == 2'd2);
    assign w_wr_level = w_wr & (address == 2'd3);
    assign w_clr      = w_wr_ctrl & writedata[3];

    // Carry-out only counts while the accumulator is actually advancing.
    assign w_sum   = {1'b0, r_acc} + {1'b0, r_ftw_active};
    assign w_carry = r_en & w_sum[PHASE_W];
    assign w_phase = r_acc + r_poff;

    // FSM state and tuning-word registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_RUN;
            r_ftw_active <= '0;
            r_ftw_pend   <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_ftw_active <= w_ftw_active_nxt;
            r_ftw_pend   <= w_ftw_pend_nxt;
        end
    end

    // Next-state: stage FTW writes while running, release them on carry-out or clear.
    always_comb begin
        w_state_nxt      = r_state;
        w_ftw_active_nxt = r_ftw_active;
        w_ftw_pend_nxt   = r_ftw_pend;
        case (r_state)
            ST_RUN: begin
                if (w_wr_ftw) begin
                    // A stopped or zeroed accumulator has no phase to protect.
                    if (!r_en || (r_acc == '0)) begin
                        w_ftw_active_nxt = writedata[PHASE_W-1:0];
                    end else begin
                        w_ftw_pend_nxt = writedata[PHASE_W-1:0];
                        w_state_nxt    = ST_PEND;
                    end
                end
            end
            ST_PEND: begin
                if (w_carry || w_clr) begin
                    w_ftw_active_nxt = r_ftw_pend;
                    w_state_nxt      = ST_RUN;
                end
                // A new write on the wrap cycle is kept for the following wrap.
                if (w_wr_ftw) begin
                    w_ftw_pend_nxt = writedata[PHASE_W-1:0];
                    w_state_nxt    = ST_PEND;
                end
            end
            default: w_state_nxt = ST_RUN;
        endcase
    end

    // Waveform mapping from the registered phase.
    always_comb begin
        w_tri_up = {r_ph[8:0], 1'b0};
        w_sample = r_ph;
        case (r_wave)
            2'd0:    w_sample = r_ph;
            2'd1:    w_sample = r_ph[9] ? ~w_tri_up : w_tri_up;
            2'd2:    w_sample = (r_ph < r_level) ? 10'h3FF : 10'h000;
            default: w_sample = r_level;
        endcase
    end

    // Control registers, accumulator and the two-stage output pipeline.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_poff       <= '0;
            r_en         <= 1'b0;
            r_wave       <= 2'd0;
            r_level      <= 10'd0;
            r_acc        <= '0;
            r_ph         <= 10'd0;
            r_dds_out    <= 10'd0;
            r_phase_wrap <= 1'b0;
        end else begin
            if (w_wr_poff) begin
                r_poff <= writedata[PHASE_W-1:0];
            end
            if (w_wr_ctrl) begin
                r_en   <= writedata[0];
                r_wave <= writedata[2:1];
            end
            if (w_wr_level) begin
                r_level <= writedata[9:0];
            end
            if (w_clr) begin
                r_acc <= '0;
            end else if (r_en) begin
                r_acc <= w_sum[PHASE_W-1:0];
            end
            r_phase_wrap <= w_carry & ~w_clr;
            r_ph         <= w_phase[PHASE_W-1 -: 10];
            r_dds_out    <= w_sample;
        end
    end

    assign dds_out    = r_dds_out;
    assign phase_wrap = r_phase_wrap;

`ifdef DDS_WAVE_GEN_READBACK_EN
    logic [31:0] r_readdata;

    // Registered read mux; CLR is self-clearing so it always reads back as 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_readdata <= 32'd0;
        end else begin
            case (address)
                2'd0:    r_readdata <= 32'(r_ftw_active);
                2'd1:    r_readdata <= 32'(r_poff);
                2'd2:    r_readdata <= {28'd0, 1'b0, r_wave, r_en};
                default: r_readdata <= {22'd0, r_level};
            endcase
        end
    end

    assign readdata = r_readdata;
`else
    logic w_unused_addr;

    assign readdata      = 32'd0;
    assign w_unused_addr = &{1'b0, address};
`endif

endmodule
